// File: rtl/stream_idct_2d_ctrl.sv
// rtl/stream_idct_2d_ctrl.sv - sequences one shared 1D IDCT core through row and column passes of an 8x8 block
// Optional feature macro: IDCT_2D_CTRL_OVERLAP_EN (next block's rows may enter while columns drain)
module stream_idct_2d_ctrl #(
  parameter int COEF_WIDTH = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [8*COEF_WIDTH-1:0] in_ch_t_data,
  input  logic                    in_ch_t_valid,
  input  logic                    in_ch_t_last,
  output logic                    in_ch_t_ready,
  output logic [8*COEF_WIDTH-1:0] idct_in_t_data,
  output logic                    idct_in_t_valid,
  output logic                    idct_in_t_last,
  output logic [COEF_WIDTH-1:0]   idct_in_t_strb,
  output logic [COEF_WIDTH-1:0]   idct_in_t_keep,
  output logic                    idct_in_t_id,
  output logic                    idct_in_t_dest,
  output logic                    idct_in_t_user,
  input  logic                    idct_in_t_ready,
  input  logic [8*COEF_WIDTH-1:0] idct_out_t_data,
  input  logic                    idct_out_t_valid,
  output logic                    idct_out_t_ready,
  output logic [8*COEF_WIDTH-1:0] out_ch_t_data,
  output logic                    out_ch_t_valid,
  output logic                    out_ch_t_last,
  output logic [COEF_WIDTH-1:0]   out_ch_t_strb,
  output logic [COEF_WIDTH-1:0]   out_ch_t_keep,
  output logic                    out_ch_t_id,
  output logic                    out_ch_t_dest,
  output logic                    out_ch_t_user,
  input  logic                    out_ch_t_ready,
  output logic                    busy,
  output logic                    err_last
);

  localparam int W = COEF_WIDTH;

  typedef enum logic [1:0] {ROWS = 2'd0, WAIT_T = 2'd1, COLS = 2'd2, DRAIN = 2'd3} state_t;

  state_t         state, state_nxt;
  logic [2:0]     issue_cnt;
  logic [3:0]     res_cnt;
  logic           rows_landed;
  logic [W-1:0]   tbuf [8][8];
  logic [8*W-1:0] col_data;
  logic           in_hs, idct_in_hs, idct_out_hs, out_hs;
  logic           row_res_hs, last_row_done;

  assign in_hs         = in_ch_t_valid && in_ch_t_ready;
  assign idct_in_hs    = idct_in_t_valid && idct_in_t_ready;
  assign idct_out_hs   = idct_out_t_valid && idct_out_t_ready;
  assign out_hs        = out_ch_t_valid && out_ch_t_ready;
  assign row_res_hs    = idct_out_hs && !res_cnt[3];
  assign last_row_done = row_res_hs && (res_cnt[2:0] == 3'd7);

  assign idct_in_t_strb = '1;
  assign idct_in_t_keep = '1;
  assign idct_in_t_id   = 1'b0;
  assign idct_in_t_dest = 1'b0;
  assign idct_in_t_user = 1'b0;
  assign out_ch_t_strb  = '1;
  assign out_ch_t_keep  = '1;
  assign out_ch_t_id    = 1'b0;
  assign out_ch_t_dest  = 1'b0;
  assign out_ch_t_user  = 1'b0;

  assign busy = (state != ROWS) || (issue_cnt != 3'd0) || (res_cnt != 4'd0);

  // Issue FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ROWS;
    else          state <= state_nxt;
  end

  // Issue FSM next state; WAIT_T also releases on the cycle the eighth row result lands
  always_comb begin
    state_nxt = state;
    case (state)
      ROWS:   if (idct_in_hs && issue_cnt == 3'd7) state_nxt = WAIT_T;
      WAIT_T: if (rows_landed || last_row_done) state_nxt = COLS;
      COLS:   if (idct_in_hs && issue_cnt == 3'd7) begin
`ifdef IDCT_2D_CTRL_OVERLAP_EN
        state_nxt = ROWS;
`else
        state_nxt = DRAIN;
`endif
      end
      DRAIN:  if (out_hs && res_cnt == 4'd15) state_nxt = ROWS;
      default: state_nxt = ROWS;
    endcase
  end

  // Issue FSM outputs: route either the input stream or a buffer column into the core
  always_comb begin
    in_ch_t_ready   = 1'b0;
    idct_in_t_valid = 1'b0;
    idct_in_t_data  = in_ch_t_data;
    idct_in_t_last  = 1'b0;
    case (state)
      ROWS: begin
        in_ch_t_ready   = idct_in_t_ready;
        idct_in_t_valid = in_ch_t_valid;
      end
      COLS: begin
        idct_in_t_valid = 1'b1;
        idct_in_t_data  = col_data;
        idct_in_t_last  = (issue_cnt == 3'd7);
      end
      default: ;
    endcase
  end

  // Column k of the transpose buffer gathered for the current column index
  always_comb begin
    col_data = '0;
    for (int k = 0; k < 8; k++) col_data[k*W +: W] = tbuf[k][issue_cnt];
  end

  // Result routing: first 8 results go to the buffer, last 8 pass straight downstream
  always_comb begin
    idct_out_t_ready = res_cnt[3] ? out_ch_t_ready : 1'b1;
    out_ch_t_valid   = res_cnt[3] && idct_out_t_valid;
    out_ch_t_data    = idct_out_t_data;
    out_ch_t_last    = (res_cnt == 4'd15);
  end

  // Issue/result counters, row-landed flag and framing error pulse.
  // rows_landed remembers that this block's row results are all in the buffer; res_cnt == 8
  // alone is ambiguous when the previous block's columns are still draining with overlap.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      issue_cnt   <= 3'd0;
      res_cnt     <= 4'd0;
      rows_landed <= 1'b0;
      err_last    <= 1'b0;
    end else begin
      if (idct_in_hs)  issue_cnt <= issue_cnt + 3'd1;
      if (idct_out_hs) res_cnt   <= res_cnt + 4'd1;
      if (state == WAIT_T && state_nxt == COLS) rows_landed <= 1'b0;
      else if (last_row_done)                   rows_landed <= 1'b1;
      err_last <= in_hs && (in_ch_t_last != (issue_cnt == 3'd7));
    end
  end

  // Transpose buffer write of row results; contents intentionally not reset
  always_ff @(posedge aclk) begin
    if (row_res_hs) begin
      for (int c = 0; c < 8; c++) tbuf[res_cnt[2:0]][c] <= idct_out_t_data[c*W +: W];
    end
  end

endmodule
